// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
package multdiv_pkg;

  localparam int WIDTH     = 32;
  localparam int ITER_LAST = WIDTH - 1;

  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [WIDTH:0] sext33(input logic [WIDTH-1:0] v);
    return {v[WIDTH-1], v};
  endfunction

endpackage

// File: rtl/addsub33.sv
// 33-bit adder/subtractor: sum = a + b when sub is low, a - b when sub is high.
module addsub33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] sum,
  output logic        cout
);

  logic [33:0] full;

  assign full = {1'b0, a} + {1'b0, b ^ {33{sub}}} + {33'd0, sub};
  assign sum  = full[32:0];
  assign cout = full[33];

endmodule

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring) sequencer.
// One shared 33-bit adder serves the iterations and the dividend negation.
module multdiv_sequencer #(
  parameter int WIDTH = multdiv_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  import multdiv_pkg::*;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   acc;       // product upper half (sign-extended) or remainder
  logic [WIDTH-1:0] lo;        // product lower half or dividend/quotient shifter
  logic             booth;
  logic [WIDTH-1:0] opnd;      // multiplicand A or divisor B
  logic [WIDTH-1:0] qm;        // quotient minus one, for sign fix-up without an adder
  logic             q_neg;
  logic             div_ovf;
  logic             div_zero;

  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic             add_sub;
  logic [WIDTH:0]   add_sum;
  logic             add_cout;

  addsub33 u_addsub (
    .a    (add_a),
    .b    (add_b),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    add_a   = '0;
    add_b   = sext33(data_operandA);
    add_sub = 1'b1;
    case (state)
      MULT: begin
        add_a   = acc;
        add_b   = sext33(opnd);
        add_sub = lo[0] & ~booth;
      end
      DIV: begin
        // A negative divisor is added, so the trial is always rem - |B|.
        add_a   = {acc[WIDTH-1:0], lo[WIDTH-1]};
        add_b   = sext33(opnd);
        add_sub = ~opnd[WIDTH-1];
      end
      default: ;
    endcase
  end

  logic [WIDTH:0]   mult_sum;
  logic             mult_ovf;
  logic             qbit;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] qm_next;
  logic [WIDTH-1:0] a_abs;
  logic             last_iter;
  logic             start_mult;
  logic             start_div;

  assign mult_sum   = (lo[0] ^ booth) ? add_sum : acc;
  // Bits 63:31 of the final product are exactly mult_sum.
  assign mult_ovf   = !((&mult_sum) || !(|mult_sum));
  // Carry out of the trial means rem >= |B| for either divisor sign.
  assign qbit       = add_cout;
  assign div_rem    = qbit ? add_sum : add_a;
  assign q_next     = {lo[WIDTH-2:0], qbit};
  assign qm_next    = qbit ? {lo[WIDTH-2:0], 1'b0} : {qm[WIDTH-2:0], 1'b1};
  assign a_abs      = data_operandA[WIDTH-1] ? add_sum[WIDTH-1:0] : data_operandA;
  assign last_iter  = (cnt == CNT_W'(ITER_LAST));
  assign start_mult = ctrl_MULT;
  assign start_div  = ctrl_DIV & ~ctrl_MULT;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      acc            <= '0;
      lo             <= '0;
      booth          <= 1'b0;
      opnd           <= '0;
      qm             <= '0;
      q_neg          <= 1'b0;
      div_ovf        <= 1'b0;
      div_zero       <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_mult) begin
            state <= MULT;
            cnt   <= '0;
            acc   <= '0;
            lo    <= data_operandB;
            booth <= 1'b0;
            opnd  <= data_operandA;
            busy  <= 1'b1;
          end else if (start_div) begin
            state    <= DIV;
            cnt      <= '0;
            acc      <= '0;
            lo       <= a_abs;
            opnd     <= data_operandB;
            qm       <= '1;
            q_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_ovf  <= (data_operandA == INT_MIN) && (data_operandB == '1);
            div_zero <= (data_operandB == '0);
            busy     <= (data_operandB != '0);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        MULT: begin
          acc   <= {mult_sum[WIDTH], mult_sum[WIDTH:1]};
          lo    <= {mult_sum[0], lo[WIDTH-1:1]};
          booth <= lo[0];
          cnt   <= cnt + CNT_W'(1);
          if (last_iter) begin
            state          <= DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= {mult_sum[0], lo[WIDTH-1:1]};
            data_exception <= mult_ovf;
          end
        end
        DIV: begin
          if (div_zero) begin
            state          <= DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= '0;
            data_exception <= 1'b1;
          end else begin
            acc <= div_rem;
            lo  <= q_next;
            qm  <= qm_next;
            cnt <= cnt + CNT_W'(1);
            if (last_iter) begin
              state          <= DONE;
              busy           <= 1'b0;
              data_resultRDY <= 1'b1;
              // -q == ~(q - 1), so the negated quotient is just ~qm.
              data_result    <= q_neg ? ~qm_next : q_next;
              data_exception <= div_ovf;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_multdiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ctrl_mult = 1'b0;
  logic        ctrl_div = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] res;
  logic        exc;
  logic        rdy;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_res = '0;

  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  always #5 clk = ~clk;

  multdiv_sequencer dut (
    .clock          (clk),
    .reset          (rst_n),
    .ctrl_MULT      (ctrl_mult),
    .ctrl_DIV       (ctrl_div),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .data_result    (res),
    .data_exception (exc),
    .data_resultRDY (rdy),
    .busy           (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // kind: 0 = multiply, 1 = divide, 2 = both starts (multiply wins)
  function automatic logic [32:0] model(input int kind, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (kind != 1) begin
      p = sa * sb;
      return {(p > MAXI || p < MINI), p[31:0]};
    end
    if (b == 32'h0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    p = sa / sb;
    return {1'b0, p[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'h1;
      4: v = 32'($urandom_range(0, 20)) - 32'd10;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic do_op(input int kind, input logic [31:0] a, input logic [31:0] b,
                       input bit b2b, input bit inject, input bit chk_pulse, input string tag);
    logic [32:0] exp;
    int lat, busy_n, exp_lat;
    bit seen, dz;
    exp     = model(kind, a, b);
    dz      = (kind == 1) && (b == 32'h0);
    exp_lat = dz ? 1 : 32;
    if (!b2b) @(negedge clk);
    ctrl_mult = (kind != 1);
    ctrl_div  = (kind != 0);
    op_a      = a;
    op_b      = b;
    @(posedge clk);
    #1;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    op_a      = $urandom;
    op_b      = $urandom;
    lat = 0; busy_n = 0; seen = 1'b0;
    while (lat < 40 && !seen) begin
      if (busy) busy_n++;
      if (lat == 16) check({tag, "_hold"}, 64'(res), 64'(last_res));
      if (inject) ctrl_div = (lat == 5);
      @(posedge clk);
      lat++;
      #1;
      seen = rdy;
    end
    ctrl_div = 1'b0;
    check({tag, "_rdy"},  64'(seen), 64'(1));
    check({tag, "_lat"},  64'(lat), 64'(exp_lat));
    check({tag, "_busy"}, 64'(busy_n), 64'(dz ? 0 : 32));
    check({tag, "_res"},  64'(res), 64'(exp[31:0]));
    check({tag, "_exc"},  64'(exc), 64'(exp[32]));
    last_res = exp[31:0];
    if (chk_pulse) begin
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, 64'({rdy, busy}), 64'(0));
    end
  endtask

  initial begin
    bit seen, nb2b, next;
    int kind;
    logic [31:0] a, b;

    #12;
    check("reset_state", 64'({res, exc, rdy, busy}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    do_op(0, 32'd7, 32'hFFFF_FFFD, 0, 0, 1, "mul_7x-3");
    do_op(0, 32'h0001_0000, 32'h0001_0000, 0, 0, 1, "mul_ovf");
    do_op(1, 32'hFFFF_FFF9, 32'd2, 0, 0, 1, "div_-7/2");
    do_op(1, 32'd100, 32'hFFFF_FFF6, 0, 0, 1, "div_100/-10");
    do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, "div_min/-1");
    do_op(1, 32'd5, 32'd0, 0, 0, 1, "div_by0");
    do_op(0, 32'd1234, 32'hFFFF_F000, 0, 1, 1, "mul_inject_div");
    do_op(2, 32'd6, 32'd7, 0, 0, 1, "both_starts");
    do_op(0, 32'd123, 32'hFFFF_FFD3, 0, 0, 0, "b2b_first");
    do_op(0, 32'hFFFF_FC18, 32'd999, 1, 0, 1, "b2b_second");

    // Abandon a multiply at iteration 10 with an asynchronous reset.
    @(negedge clk);
    ctrl_mult = 1'b1;
    op_a = 32'd77;
    op_b = 32'd55;
    @(posedge clk);
    #1;
    ctrl_mult = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", 64'({res, exc, rdy, busy}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (rdy) seen = 1'b1;
    end
    check("rst_no_rdy", 64'(seen), 64'(0));
    last_res = '0;
    do_op(0, 32'hFFFF_FF85, 32'd300, 0, 0, 1, "after_rst");

    nb2b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      a    = pick();
      b    = pick();
      next = (i == 39) ? 1'b0 : 1'($urandom_range(0, 1));
      do_op(kind, a, b, nb2b, 0, !next, "rnd");
      nb2b = next;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
